// File: rtl/reg_ctrl.sv
// Purpose: four-state register-file controller (IDLE/READ/EXEC/WB) driving read/write selects and ALU op.
// Latency: 4 cycles from acceptance edge back to IDLE; all outputs registered, no input-to-output path.
// Backpressure: instr_ready is high only in IDLE; instructions offered in other states are left pending.
module reg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] INSTR,
  output logic       instr_ready,
  output logic [1:0] SEL_A,
  output logic [1:0] SEL_B,
  output logic [1:0] SEL_W,
  output logic       write_en,
  output logic [1:0] ALU_OP,
  output logic       done,
  output logic [7:0] RETIRED
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b11;

  state_t     state;
  logic [7:0] instr_q;

  // Single FSM: every output is a flop loaded with the value for the state being entered,
  // so outputs depend only on state and the latched instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_q     <= 8'h00;
      RETIRED     <= 8'h00;
      instr_ready <= 1'b1;
      SEL_A       <= 2'b00;
      SEL_B       <= 2'b00;
      SEL_W       <= 2'b00;
      ALU_OP      <= 2'b00;
      write_en    <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            // Selects must be valid in the READ cycle, so they load straight from INSTR here.
            state       <= READ;
            instr_q     <= INSTR;
            instr_ready <= 1'b0;
            ALU_OP      <= INSTR[7:6];
            SEL_A       <= INSTR[3:2];
            SEL_B       <= INSTR[1:0];
          end
        end
        READ: begin
          state  <= EXEC;
          ALU_OP <= instr_q[7:6];
          SEL_A  <= instr_q[3:2];
          SEL_B  <= instr_q[1:0];
        end
        EXEC: begin
          // Reads are finished by now, so rd may alias rs1/rs2 without a stall.
          state    <= WB;
          SEL_A    <= 2'b00;
          SEL_B    <= 2'b00;
          SEL_W    <= instr_q[5:4];
          write_en <= (instr_q[7:6] != OP_NOP);
          done     <= 1'b1;
        end
        WB: begin
          state       <= IDLE;
          RETIRED     <= RETIRED + 8'd1;
          instr_ready <= 1'b1;
          SEL_W       <= 2'b00;
          ALU_OP      <= 2'b00;
          write_en    <= 1'b0;
          done        <= 1'b0;
        end
        default: begin
          // Unknown encoding: recover to a clean IDLE.
          state       <= IDLE;
          instr_ready <= 1'b1;
          SEL_A       <= 2'b00;
          SEL_B       <= 2'b00;
          SEL_W       <= 2'b00;
          ALU_OP      <= 2'b00;
          write_en    <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_ctrl.sv
// Purpose: directed self-checking bench for reg_ctrl.
// Latency: checks READ/EXEC/WB timing against a 4-edge instruction cycle.
// Backpressure: holds instr_valid high across busy cycles to confirm no early acceptance.
module tb_reg_ctrl;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [7:0] INSTR;
  logic       instr_ready;
  logic [1:0] SEL_A;
  logic [1:0] SEL_B;
  logic [1:0] SEL_W;
  logic       write_en;
  logic [1:0] ALU_OP;
  logic       done;
  logic [7:0] RETIRED;

  int vectors;
  int miscompares;
  logic [7:0] exp_retired;

  reg_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .INSTR       (INSTR),
    .instr_ready (instr_ready),
    .SEL_A       (SEL_A),
    .SEL_B       (SEL_B),
    .SEL_W       (SEL_W),
    .write_en    (write_en),
    .ALU_OP      (ALU_OP),
    .done        (done),
    .RETIRED     (RETIRED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: active edge, then back to the falling edge where we sample and drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    INSTR = 8'hFF;
    #1;
    vectors++;
    if ({instr_ready, write_en, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctl: got ready/we/done=%b want 100", {instr_ready, write_en, done});
    end
    vectors++;
    if ({SEL_A, SEL_B, SEL_W, ALU_OP, RETIRED} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_dat: got sels/op/retired=%h want 0000", {SEL_A, SEL_B, SEL_W, ALU_OP, RETIRED});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_retired = 8'h00;
    vectors++;
    if (instr_ready !== 1'b1 || SEL_A !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release_idle: got ready=%b sel_a=%b want 1 00", instr_ready, SEL_A);
    end
  endtask

  task automatic test_basic_write();
    instr_valid = 1'b1;
    INSTR = 8'h1B;
    tick();
    instr_valid = 1'b0;
    INSTR = 8'h00;
    vectors++;
    if ({instr_ready, SEL_A, SEL_B, ALU_OP, write_en, done} !== {1'b0, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_read: got rdy/a/b/op/we/dn=%b want 0101100000", {instr_ready, SEL_A, SEL_B, ALU_OP, write_en, done});
    end
    tick();
    vectors++;
    if ({SEL_A, SEL_B, SEL_W, write_en} !== {2'b10, 2'b11, 2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_exec: got a/b/w/we=%b want 101100 0", {SEL_A, SEL_B, SEL_W, write_en});
    end
    tick();
    vectors++;
    if ({write_en, done, SEL_W, ALU_OP} !== {1'b1, 1'b1, 2'b01, 2'b00}) begin
      miscompares++;
      $display("FAIL basic_wb: got we/dn/w/op=%b want 110100", {write_en, done, SEL_W, ALU_OP});
    end
    tick();
    exp_retired = exp_retired + 8'd1;
    vectors++;
    if (RETIRED !== exp_retired || {instr_ready, write_en, done, SEL_W, ALU_OP} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL basic_idle: got retired=%h ctl=%b want %h 1000000", RETIRED, {instr_ready, write_en, done, SEL_W, ALU_OP}, exp_retired);
    end
  endtask

  task automatic test_nop();
    instr_valid = 1'b1;
    INSTR = 8'hE4;
    tick();
    instr_valid = 1'b0;
    vectors++;
    if ({ALU_OP, SEL_A, SEL_B} !== 6'b110100) begin
      miscompares++;
      $display("FAIL nop_read: got op/a/b=%b want 110100", {ALU_OP, SEL_A, SEL_B});
    end
    tick();
    tick();
    vectors++;
    if ({done, write_en, SEL_W} !== 4'b1010) begin
      miscompares++;
      $display("FAIL nop_wb: got dn/we/w=%b want 1010", {done, write_en, SEL_W});
    end
    tick();
    exp_retired = exp_retired + 8'd1;
    vectors++;
    if (RETIRED !== exp_retired) begin
      miscompares++;
      $display("FAIL nop_retired: got %h want %h", RETIRED, exp_retired);
    end
  endtask

  task automatic test_alias();
    instr_valid = 1'b1;
    INSTR = 8'h55;
    tick();
    instr_valid = 1'b0;
    vectors++;
    if ({SEL_A, SEL_B, ALU_OP} !== 6'b010101) begin
      miscompares++;
      $display("FAIL alias_read: got a/b/op=%b want 010101", {SEL_A, SEL_B, ALU_OP});
    end
    tick();
    vectors++;
    if ({SEL_A, SEL_B} !== 4'b0101) begin
      miscompares++;
      $display("FAIL alias_exec: got a/b=%b want 0101", {SEL_A, SEL_B});
    end
    tick();
    vectors++;
    if ({SEL_W, write_en, done} !== 4'b0111) begin
      miscompares++;
      $display("FAIL alias_wb: got w/we/dn=%b want 0111", {SEL_W, write_en, done});
    end
    tick();
    exp_retired = exp_retired + 8'd1;
    vectors++;
    if (RETIRED !== exp_retired) begin
      miscompares++;
      $display("FAIL alias_retired: got %h want %h", RETIRED, exp_retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prog [3];
    logic [7:0] cur;
    logic [1:0] want_we;
    prog[0] = 8'h9C;
    prog[1] = 8'h27;
    prog[2] = 8'hF0;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cur = prog[k];
      INSTR = cur;
      vectors++;
      if (instr_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready_idle[%0d]: got %b want 1", k, instr_ready);
      end
      tick();
      INSTR = ~cur;
      vectors++;
      if ({instr_ready, SEL_A, SEL_B, ALU_OP} !== {1'b0, cur[3:2], cur[1:0], cur[7:6]}) begin
        miscompares++;
        $display("FAIL b2b_read[%0d]: got %b want %b", k, {instr_ready, SEL_A, SEL_B, ALU_OP}, {1'b0, cur[3:2], cur[1:0], cur[7:6]});
      end
      tick();
      INSTR = 8'h3A;
      vectors++;
      if ({instr_ready, SEL_A, SEL_B} !== {1'b0, cur[3:2], cur[1:0]}) begin
        miscompares++;
        $display("FAIL b2b_exec[%0d]: got %b want %b", k, {instr_ready, SEL_A, SEL_B}, {1'b0, cur[3:2], cur[1:0]});
      end
      tick();
      want_we = (cur[7:6] == 2'b11) ? 2'b01 : 2'b11;
      vectors++;
      if ({instr_ready, SEL_W, write_en, done} !== {1'b0, cur[5:4], want_we}) begin
        miscompares++;
        $display("FAIL b2b_wb[%0d]: got %b want %b", k, {instr_ready, SEL_W, write_en, done}, {1'b0, cur[5:4], want_we});
      end
      tick();
      exp_retired = exp_retired + 8'd1;
    end
    instr_valid = 1'b0;
    vectors++;
    if (RETIRED !== exp_retired || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_end: got retired=%h ready=%b want %h 1", RETIRED, instr_ready, exp_retired);
    end
  endtask

  task automatic test_reset_in_wb();
    instr_valid = 1'b1;
    INSTR = 8'h2D;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (write_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rstwb_pre: got we=%b want 1", write_en);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({write_en, done, instr_ready, RETIRED, SEL_W} !== {3'b001, 8'h00, 2'b00}) begin
      miscompares++;
      $display("FAIL rstwb_async: got we/dn/rdy/ret/w=%b want 0010000000000", {write_en, done, instr_ready, RETIRED, SEL_W});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_retired = 8'h00;
    tick();
    vectors++;
    if (instr_ready !== 1'b1 || RETIRED !== 8'h00 || ALU_OP !== 2'b00) begin
      miscompares++;
      $display("FAIL rstwb_no_accept: got rdy=%b ret=%h op=%b want 1 00 00", instr_ready, RETIRED, ALU_OP);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    INSTR = 8'h7E;
    for (int n = 1; n <= 256; n++) begin
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      if (done === 1'b1) pulses++;
      tick();
      exp_retired = exp_retired + 8'd1;
      if (n == 255) begin
        vectors++;
        if (RETIRED !== 8'hFF) begin
          miscompares++;
          $display("FAIL wrap_ff: got %h want ff", RETIRED);
        end
      end
    end
    vectors++;
    if (RETIRED !== 8'h00 || exp_retired !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_00: got %h want 00", RETIRED);
    end
    vectors++;
    if (pulses != 256) begin
      miscompares++;
      $display("FAIL wrap_done_pulses: got %0d want 256", pulses);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_retired = 8'h00;
    test_reset();
    test_basic_write();
    test_nop();
    test_alias();
    test_back_to_back();
    test_reset_in_wb();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
